sc_bus_arb: RTL
===============

SC_BUS_ARB -- requirements
Module: sc_bus_arb

Interface
REQ-001 SHALL have parameter N_BEATS_MAX, default 15, meaning the max consecutive m1 grants under lock before forced release.
REQ-002 SHALL have port clk_i, input, 1, system clock, rising-edge active.
REQ-003 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports m0_req_i/m1_req_i, input, 1 each, access request from core LSU (m0) and loader/DMA (m1).
REQ-005 SHALL have ports mX_we_i (1), mX_addr_i (32), mX_wdata_i (32), mX_be_i (4), input, request attributes, valid while mX_req_i is high.
REQ-006 SHALL have port m1_lock_i, input, 1, m1 requests back-to-back ownership.
REQ-007 SHALL have ports mX_gnt_o (1), mX_rvalid_o (1), mX_rdata_o (32), output, grant, response pulse and read data.
REQ-008 SHALL have ports bus_addr_o (32), bus_wdata_o (32), bus_be_o (4), bus_we_o (1), output, drive to sc_bus.
REQ-009 SHALL have port bus_rdata_i, input, 32, combinational read data from sc_bus.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-011 In IDLE with any req, SHALL assert exactly one mX_gnt_o combinationally that cycle, latch that master's we/addr/wdata/be, record owner, go to ACCESS.
REQ-012 gnt_o SHALL be asserted only in IDLE; requests in ACCESS/RESP SHALL wait (req held by master until gnt).
REQ-013 Arbitration SHALL be round-robin: with both requesting, grant master not granted last; last-grant pointer reset value selects m0 first.
REQ-014 If lock_cnt > 0 (m1 locked) and m1_req_i high, m1 SHALL win regardless of pointer.
REQ-015 lock_cnt SHALL increment on each m1 grant with m1_lock_i high, clear on any m0 grant or m1 grant with lock low; at N_BEATS_MAX lock SHALL be ignored for the next arbitration (m0 wins if requesting).
REQ-016 In ACCESS, bus_* SHALL drive latched values, bus_we_o = latched we; bus_rdata_i SHALL be registered into rdata reg; go to RESP.
REQ-017 Outside ACCESS, bus_we_o and bus_be_o SHALL be 0; bus_addr_o/bus_wdata_o SHALL hold last latched values.
REQ-018 In RESP, owner's rvalid_o SHALL pulse one cycle, owner's rdata_o = registered rdata (also for writes); then IDLE.
REQ-019 Latency: gnt cycle N, bus access N+1, rvalid N+2; max throughput one access per 3 cycles.
REQ-020 Non-owner rvalid_o SHALL stay 0; non-owner rdata_o SHALL be 0.
REQ-021 Simultaneous req from both in IDLE SHALL produce one grant only; loser's gnt low.
REQ-022 req dropped before gnt SHALL not be granted (no latched stale request).

Reset
REQ-023 On rst_ni low, asynchronously: state IDLE, pointer=m1-last, lock_cnt 0, latched addr/wdata/be/we 0, rdata 0.
REQ-024 During reset all outputs SHALL be 0, including gnt_o (combinational gnt gated by reset).
REQ-025 Reset mid-ACCESS or mid-RESP SHALL abort the transaction; no rvalid SHALL be issued after release.
REQ-026 Reset deassertion SHALL take effect on the first rising clk_i edge after release.

Structure
REQ-027 FSM state enum, owner encoding and bus address constants (LB 0xFF000000, TTY 0xFF000004) SHALL reside in shared package sc_pkg.
REQ-028 Round-robin pick and lock counter SHALL be sub-module sc_rr_arb2; FSM and datapath regs stay in sc_bus_arb.
REQ-029 Implementation SHALL be 120-400 lines, no latches, single clock domain.

Verification
REQ-030 m0 read addr 0x00000010, bus_rdata_i=0xDEADBEEF -> m0_gnt cycle N, bus_we_o=0/be=0xF at N+1, m0_rvalid with 0xDEADBEEF at N+2.
REQ-031 Both req continuously, no lock -> grants alternate m0,m1,m0,m1 every 3 cycles; each rvalid to correct owner.
REQ-032 m1 write 0x41 to 0xFF000004 be=0x1 with lock, m0 also requesting -> m1 gets 15 consecutive grants, 16th grant to m0.
REQ-033 m0 write 0x12345678 to 0xFF000000 -> bus_we_o high exactly one cycle with bus_wdata_o=0x12345678, be=0xF; no we in IDLE/RESP.
REQ-034 Assert rst_ni low during ACCESS -> all outputs 0 immediately; after release no rvalid; next req granted to m0 first.
REQ-035 m0_req pulses one cycle while arbiter in RESP -> no m0 grant, bus stays idle.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and constants for the sc_bus single-slave arbiter slice.
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  localparam logic [31:0] ADDR_LB  = 32'hFF00_0000;
  localparam logic [31:0] ADDR_TTY = 32'hFF00_0004;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_req_t;

endpackage

// File: rtl/sc_rr_arb2.sv
// Two-master round-robin pick with a bounded m1 lock counter.
module sc_rr_arb2
  import sc_pkg::*;
#(
  parameter int N_BEATS_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic lock1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  localparam int CW = $clog2(N_BEATS_MAX + 1);

  owner_e        last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_act, pick1;

  always_comb begin
    // a lock that has reached its beat budget yields one arbitration to round-robin
    lock_act = (cnt_q != '0) && (cnt_q < CW'(N_BEATS_MAX));
    if (req1_i && lock_act)    pick1 = 1'b1;
    else if (req0_i && req1_i) pick1 = (last_q == OWN_M0);
    else                       pick1 = req1_i;
    gnt1_o = en_i & pick1;
    gnt0_o = en_i & req0_i & ~pick1;

    last_d = last_q;
    cnt_d  = cnt_q;
    if (gnt0_o) begin
      last_d = OWN_M0;
      cnt_d  = '0;
    end else if (gnt1_o) begin
      last_d = OWN_M1;
      if (!lock1_i)                        cnt_d = '0;
      else if (cnt_q == CW'(N_BEATS_MAX))  cnt_d = CW'(1);
      else                                 cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= OWN_M1;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sc_bus_arb.sv
// Arbitrates LSU (m0) and loader/DMA (m1) onto sc_bus: grant, one access cycle, one response cycle.
module sc_bus_arb
  import sc_pkg::*;
#(
  parameter int N_BEATS_MAX = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_be_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_be_i,
  input  logic        m1_lock_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  output logic        bus_we_o,
  input  logic [31:0] bus_rdata_i
);

  bus_state_e  state_q, state_d;
  owner_e      owner_q;
  bus_req_t    req_q;
  logic [31:0] rdata_q;
  logic        arb_en, gnt0, gnt1, in_acc, in_resp;

  // reset gates the combinational grant so nothing leaks out while held in reset
  assign arb_en = rst_ni && (state_q == ST_IDLE);

  sc_rr_arb2 #(.N_BEATS_MAX(N_BEATS_MAX)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (arb_en),
    .req0_i (m0_req_i),
    .req1_i (m1_req_i),
    .lock1_i(m1_lock_i),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (gnt0 || gnt1) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_M0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (gnt0) begin
        owner_q <= OWN_M0;
        req_q   <= '{we: m0_we_i, addr: m0_addr_i, wdata: m0_wdata_i, be: m0_be_i};
      end else if (gnt1) begin
        owner_q <= OWN_M1;
        req_q   <= '{we: m1_we_i, addr: m1_addr_i, wdata: m1_wdata_i, be: m1_be_i};
      end
      if (state_q == ST_ACCESS) rdata_q <= bus_rdata_i;
    end
  end

  assign in_acc  = (state_q == ST_ACCESS);
  assign in_resp = (state_q == ST_RESP);

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign bus_addr_o  = req_q.addr;
  assign bus_wdata_o = req_q.wdata;
  assign bus_we_o    = in_acc & req_q.we;
  assign bus_be_o    = in_acc ? req_q.be : 4'h0;

  assign m0_rvalid_o = in_resp && (owner_q == OWN_M0);
  assign m1_rvalid_o = in_resp && (owner_q == OWN_M1);
  assign m0_rdata_o  = m0_rvalid_o ? rdata_q : 32'h0;
  assign m1_rdata_o  = m1_rvalid_o ? rdata_q : 32'h0;

endmodule
